// File: rtl/sync_fifo_v2_if.sv
// Bus bundle for sync_fifo_v2: write/read handshakes, thresholds and status flags.
// The FIFO takes the slave modport; a producer/consumer takes the master modport.
interface sync_fifo_v2_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [CW-1:0]    af_thresh;
  logic [CW-1:0]    ae_thresh;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    fill_level;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    max_level;

  modport master (
    output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           fill_level, overflow, underflow, max_level
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           fill_level, overflow, underflow, max_level
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with arbitrary DEPTH, standard or FWFT read, flush and sticky error flags.
// Define FIFO_WATERMARK_EN to make max_level a live high-watermark register (else tied to 0).
module sync_fifo_v2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12,
  parameter int FWFT  = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  sync_fifo_v2_if.slave bus
);
  localparam int                ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full, empty, rd_acc, wr_acc;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    rd_acc   = bus.rd_en & ~empty & ~bus.flush;
    wr_acc   = bus.wr_en & (~full | rd_acc) & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (bus.wr_en & full & ~rd_acc);
      udf_d = udf_q | (bus.rd_en & empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset; a write-through read sees the old word here.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Gated to zero while empty so a reset or drained FIFO never shows stale storage.
    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = empty ? '0 : mem[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= bus.af_thresh);
  assign bus.almost_empty = (count_q <= bus.ae_thresh);
  assign bus.fill_level   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (bus.flush)            max_d = '0;
    else if (count_d > max_q) max_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= '0;
    else        max_q <= max_d;
  end

  assign bus.max_level = max_q;
`else
  assign bus.max_level = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Randomized bench for sync_fifo_v2: a standard-mode and an FWFT instance share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_sync_fifo_v2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush_s, wr_en_s, rd_en_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [CW-1:0]    af_s, ae_s;

  sync_fifo_v2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_v2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus0.flush = flush_s;   assign bus1.flush = flush_s;
  assign bus0.wr_en = wr_en_s;   assign bus1.wr_en = wr_en_s;
  assign bus0.rd_en = rd_en_s;   assign bus1.rd_en = rd_en_s;
  assign bus0.wr_data = wr_data_s; assign bus1.wr_data = wr_data_s;
  assign bus0.af_thresh = af_s;  assign bus1.af_thresh = af_s;
  assign bus0.ae_thresh = ae_s;  assign bus1.ae_thresh = ae_s;

  sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // Reference model state
  logic [WIDTH-1:0] q[$];
  int               m_ovf, m_udf, m_max;
  logic             e_vld;
  logic [WIDTH-1:0] e_dat;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_max();
`ifdef FIFO_WATERMARK_EN
    return m_max;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_max = 0;
    e_vld = 1'b0; e_dat = '0;
  endtask

  task automatic model_step(input logic f, input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit rd_ok, wr_ok;
    if (f) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_max = 0;
      e_vld = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (w && q.size() == DEPTH && !rd_ok) m_ovf = 1;
      if (r && q.size() == 0) m_udf = 1;
      e_vld = rd_ok;
      if (rd_ok) e_dat = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (q.size() > m_max) m_max = q.size();
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("fill_std",  bus0.fill_level, n);
    chk("fill_fwft", bus1.fill_level, n);
    chk("full",  bus0.full,  n == DEPTH);
    chk("empty", bus0.empty, n == 0);
    chk("afull", bus0.almost_full,  n >= int'(af_s));
    chk("aempty", bus0.almost_empty, n <= int'(ae_s));
    chk("ovf",  bus0.overflow,  m_ovf);
    chk("udf",  bus0.underflow, m_udf);
    chk("ovf_fwft", bus1.overflow,  m_ovf);
    chk("udf_fwft", bus1.underflow, m_udf);
    chk("maxlvl", bus0.max_level, exp_max());
    chk("vld_std", bus0.rd_valid, e_vld);
    chk("dat_std", bus0.rd_data,  e_dat);
    chk("vld_fwft", bus1.rd_valid, n > 0);
    if (n > 0) chk("dat_fwft", bus1.rd_data, q[0]);
  endtask

  task automatic step(input logic f, input logic w, input logic r, input logic [WIDTH-1:0] d);
    flush_s = f; wr_en_s = w; rd_en_s = r; wr_data_s = d;
    @(posedge clk);
    model_step(f, w, r, d);
    #1;
    check_all();
  endtask

  initial begin
    int pw, pr;
    flush_s = 1'b0; wr_en_s = 1'b0; rd_en_s = 1'b0; wr_data_s = '0;
    af_s = CW'(10); ae_s = CW'(2);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", bus0.empty, 1);
    chk("rst_full",  bus0.full, 0);
    chk("rst_fill",  bus0.fill_level, 0);
    chk("rst_vld",   bus0.rd_valid, 0);
    chk("rst_dat",   bus0.rd_data, 0);
    chk("rst_vld_fwft", bus1.rd_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill 0x01..0x0C, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, WIDTH'(i));
    chk("full_at12", bus0.full, 1);
    chk("lvl_at12",  bus0.fill_level, 12);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
    chk("empty_after_drain", bus0.empty, 1);

    // Write-through while full, 0xAA emerges on the 12th read
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, WIDTH'(8'h10 + i));
    step(0, 1, 1, 8'hAA);
    chk("wt_lvl", bus0.fill_level, 12);
    chk("wt_ovf", bus0.overflow, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
    chk("wt_last", bus0.rd_data, 8'hAA);

    // Overflow, underflow, flush
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, WIDTH'(8'h30 + i));
    step(0, 1, 0, 8'h77);
    chk("ovf_set", bus0.overflow, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    chk("udf_set", bus0.underflow, 1);
    step(1, 1, 1, 8'h55);
    chk("flush_ovf", bus0.overflow, 0);
    chk("flush_udf", bus0.underflow, 0);
    chk("flush_lvl", bus0.fill_level, 0);

    // FWFT fall-through and pop
    step(0, 1, 0, 8'h5A);
    chk("fwft_vld", bus1.rd_valid, 1);
    chk("fwft_dat", bus1.rd_data, 8'h5A);
    step(0, 0, 1, '0);
    chk("fwft_pop_empty", bus1.empty, 1);
    chk("fwft_pop_vld",   bus1.rd_valid, 0);

    // Watermark: peak of 7
    step(1, 0, 0, '0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, WIDTH'($urandom));
    for (int i = 0; i < 7; i++) step(0, 0, 1, '0);
    chk("wm_peak", bus0.max_level, exp_max());

    // Randomized traffic with biased phases, threshold changes and a mid-burst reset
    pw = 50; pr = 50;
    for (int i = 0; i < 2400; i++) begin
      if (i % 200 == 0) begin
        pw = $urandom_range(90, 10);
        pr = $urandom_range(90, 10);
      end
      if (i % 50 == 0) begin
        af_s = CW'($urandom_range(15));
        ae_s = CW'($urandom_range(15));
      end
      if (i == 1200) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_fill",  bus0.fill_level, 0);
        chk("arst_empty", bus0.empty, 1);
        chk("arst_vld",   bus0.rd_valid, 0);
        chk("arst_dat",   bus0.rd_data, 0);
        chk("arst_vld_fwft", bus1.rd_valid, 0);
        chk("arst_dat_fwft", bus1.rd_data, 0);
        chk("arst_ovf",   bus0.overflow, 0);
        chk("arst_udf",   bus0.underflow, 0);
        chk("arst_max",   bus0.max_level, 0);
        flush_s = 1'b0; wr_en_s = 1'b0; rd_en_s = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();
      end
      step(($urandom_range(63) == 0),
           ($urandom_range(99) < pw),
           ($urandom_range(99) < pr),
           WIDTH'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
- Second-generation single-clock FIFO: arbitrary (non-power-of-two) DEPTH, selectable standard or first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds.
- Adds synchronous flush, write-through-when-full (simultaneous pop frees the slot) and sticky overflow/underflow error flags.
- Drop-in buffer between streaming producers/consumers in the same clock domain.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 12, number of entries (>=2, not restricted to power of two).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), width of the count and threshold signals (derived; do not override).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read/pop request.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data valid qualifier.
- af_thresh  in  CW  almost-full threshold.
- ae_thresh  in  CW  almost-empty threshold.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- fill_level  out  CW  current entry count.
- overflow  out  1  sticky: write dropped.
- underflow  out  1  sticky: read of empty FIFO.
- max_level  out  CW  high-watermark (see Optional Feature).

Behaviour:
- Reset (async, rst_n low): pointers, count, rd_data, rd_valid, overflow, underflow, max_level = 0. Hence empty=1, full=0, fill_level=0. Memory contents are not reset.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc); write-through when full requires a same-cycle accepted read.
- Pointers: ADDR_W = $clog2(DEPTH) bits each. Increment wraps DEPTH-1 -> 0 explicitly, no modulo-2^n. Full/empty come from a registered count, not pointer MSB compare.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Standard mode (FWFT=0):
  - rd_data <= mem[rd_ptr] on rd_acc, else holds.
  - rd_valid = 1 for exactly the cycle after rd_acc.
  - Read latency 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the displayed word.
  - Write into empty FIFO is visible on rd_data one cycle after the write edge.
- Empty with simultaneous wr/rd: read rejected (rd_acc=0), write accepted, count -> 1.
- Flags are combinational from registered count and threshold inputs. A threshold of 0 makes almost_full constantly 1. A threshold >= DEPTH makes almost_empty constantly 1.
- overflow set on wr_en & full & !rd_acc. underflow set on rd_en & empty. Both stay set until flush or reset.
- flush: next edge sets pointers, count, overflow, underflow, max_level to 0 and rd_valid to 0. flush overrides wr_en/rd_en that cycle; neither is accepted nor flagged. rd_data is not cleared.
- Reset mid-operation: immediate async clear as above; in-flight rd_valid is lost.

Optional Feature:
- Macro FIFO_WATERMARK_EN.
  - Defined: max_level is a register updated each cycle to max(max_level, next count). Cleared by reset/flush.
  - Undefined: max_level tied to 0, no register inferred. Port list is unchanged.

Test Plan:
- DEPTH=12, FWFT=0: write 0x01..0x0C -> full=1 after 12th edge, fill_level=12. Read 12 -> rd_data 0x01..0x0C in order, each one cycle after rd_en with rd_valid pulse. Ends empty=1.
- Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> count stays 12, overflow stays 0. 0xAA is read out 12 reads later. Wrap from entry 11 to 0 is exercised.
- FWFT=1, empty, write 0x5A -> next cycle rd_valid=1, rd_data=0x5A with no rd_en. rd_en then pops -> empty=1, rd_valid=0.
- wr_en with full and no read -> overflow=1, count 12, data unchanged. rd_en with empty -> underflow=1. flush -> both 0, fill_level=0.
- af_thresh=10, ae_thresh=2: fill to 2 -> almost_empty=1. At 3 -> 0. At 10 -> almost_full=1. At 9 -> 0.
- FIFO_WATERMARK_EN: fill to 7, drain to 0 -> max_level=7. Assert rst_n low mid-burst -> all outputs 0 immediately.
